bitstream_gen_array: RTL and testbench
======================================

BITSTREAM_GEN_ARRAY -- requirements
Module: bitstream_gen_array

Interface
REQ-001 SHALL have parameter IDIM, default 4, number of parallel lanes.
REQ-002 SHALL have parameter IWID, default 8, binary input width; frame length N = 2^IWID cycles.
REQ-003 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iValid  input  1  a frame of input values is offered.
REQ-006 SHALL have port oReady  output  1  the block accepts the offered frame this cycle.
REQ-007 SHALL have port iData  input  IDIM x IWID  unsigned per-lane values, unpacked array.
REQ-008 SHALL have port iFlush  input  1  synchronous abort of the current frame.
REQ-009 SHALL have port oBit  output  IDIM x 1  unipolar bitstream, one bit per lane per cycle, unpacked array.
REQ-010 SHALL have port oBitValid  output  1  oBit carries a frame bit this cycle.
REQ-011 SHALL have port oAccSel  output  1  bank select for the downstream double-buffer accumulator.
REQ-012 SHALL have port oClear  output  1  clear strobe for the downstream accumulator bank.
REQ-013 SHALL have port oFrameDone  output  1  one-cycle pulse on the last bit of a frame.

Function
REQ-014 SHALL implement FSM states IDLE and RUN, with an IWID-bit cycle counter cnt.
REQ-015 SHALL drive oReady high in IDLE, and in RUN only when cnt == N-1 and iFlush is low.
REQ-016 SHALL accept a frame on an edge where iValid && oReady: latch iData, enter RUN, set cnt = 0.
REQ-017 SHALL stay in IDLE and hold the latched data when iValid is low in IDLE.
REQ-018 SHALL, in RUN, increment cnt every cycle and wrap N-1 -> 0.
REQ-019 SHALL, at cnt == N-1, start the next frame without a bubble if a frame is accepted, else go to IDLE.
REQ-020 SHALL form rng = bit-reverse(cnt).
REQ-021 SHALL set oBit[i] = (data[i] > rng_i), combinational from registered state; rng_i = rng unless the configuration option applies.
REQ-022 SHALL make lane i emit exactly data[i] ones per frame; value 0 gives all zeros, and the maximum is N-1 ones.
REQ-023 SHALL set oBitValid = (state == RUN); the first bit appears in the cycle after acceptance.
REQ-024 SHALL drive oClear high exactly when RUN and cnt == 0.
REQ-025 SHALL drive oFrameDone high exactly when RUN, cnt == N-1 and iFlush is low.
REQ-026 SHALL toggle oAccSel (registered) on every edge where oFrameDone is high.
REQ-027 SHALL, on iFlush high in RUN: return to IDLE at the next edge, with no oFrameDone and no oAccSel toggle.
REQ-028 SHALL give iFlush priority over an acceptance in the same cycle; that frame is not accepted.
REQ-029 SHALL ignore iFlush in IDLE.
REQ-030 SHALL sample iData only on the accept edge; iData changes during RUN do not affect oBit.

Reset
REQ-031 SHALL, on rst_n low, asynchronously set state = IDLE, cnt = 0, latched data = 0 and oAccSel = 0.
REQ-032 SHALL, therefore, drive oBitValid = 0, oClear = 0, oFrameDone = 0 and oBit = 0 during reset, and oReady = 1 after reset.
REQ-033 SHALL, on reset mid-frame, discard the frame and produce no oFrameDone.

Configuration
REQ-034 SHALL support macro DECORR_EN: when defined, rng_i = rng rotated left by i mod IWID bits, to decorrelate lanes; when undefined, all lanes share rng.
REQ-035 SHALL preserve REQ-022 exactly in both configurations, since rotation permutes the full period.

Structure
REQ-036 SHALL place the FSM state enum (IDLE, RUN) and a bit-reverse function in shared package bitstream_gen_pkg.
REQ-037 SHALL use one sub-module, bitstream_rng, holding cnt and producing rng and the wrap flag.

Verification
REQ-038 SHALL test reset: hold rst_n = 0 for 100 ns -> oReady = 1, oBitValid = 0, oAccSel = 0, oBit all 0.
REQ-039 SHALL test counts: IWID = 8, iData = {0, 1, 128, 255}, one frame -> per-lane ones over 256 cycles = {0, 1, 128, 255}; oClear on the first cycle; oFrameDone on cycle 256; oAccSel 0 -> 1.
REQ-040 SHALL test back-to-back: iValid held high over two frames -> 512 contiguous oBitValid cycles, oAccSel toggles twice and ends at 0, the second frame's counts match its data.
REQ-041 SHALL test flush: iFlush at cnt = 50 -> IDLE next cycle, no oFrameDone, oAccSel unchanged.
REQ-042 SHALL test flush versus accept: iFlush and iValid both high at cnt = 255 -> no acceptance and IDLE next cycle.
REQ-043 SHALL test DECORR_EN: with the macro defined, iData = 128 on all lanes -> lanes 0 and 1 differ in at least one cycle, and every lane still counts 128.

Source files
------------

// File: rtl/bitstream_gen_pkg.sv
// Shared types and helpers for the bitstream generator array.
package bitstream_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MAX_W = 32;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bitstream_rng.sv
// Frame cycle counter and its bit-reversed value, used as the shared comparison threshold.
module bitstream_rng
    import bitstream_gen_pkg::*;
#(
    parameter int IWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    output logic [IWID-1:0] cnt_o,
    output logic [IWID-1:0] rng_o,
    output logic            wrap_o
);

    logic [IWID-1:0] cnt_q;
    logic [IWID-1:0] cnt_d;

    // Any cycle without advance parks the counter at zero, ready for the next frame.
    always_comb begin
        cnt_d = '0;
        if (en_i) cnt_d = cnt_q + IWID'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign rng_o  = IWID'(bit_reverse(MAX_W'(cnt_q), IWID));
    assign wrap_o = (cnt_q == {IWID{1'b1}});

endmodule

// File: rtl/bitstream_gen_array.sv
// Parallel unipolar bitstream generator: each lane emits data[i] ones per 2^IWID-cycle frame.
// Define DECORR_EN to rotate the threshold per lane so lanes are decorrelated.
module bitstream_gen_array
    import bitstream_gen_pkg::*;
#(
    parameter int IDIM = 4,
    parameter int IWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iValid,
    output logic            oReady,
    input  logic [IWID-1:0] iData [IDIM],
    input  logic            iFlush,
    output logic            oBit [IDIM],
    output logic            oBitValid,
    output logic            oAccSel,
    output logic            oClear,
    output logic            oFrameDone,
    output state_e          oDbgState
);

    // Handshake: a frame transfers on a rising edge where iValid && oReady.
    // oReady depends combinationally on iFlush so a flush always wins over acceptance.

    state_e          state_q, state_d;
    logic [IWID-1:0] data_q [IDIM];
    logic [IWID-1:0] data_d [IDIM];
    logic            acc_sel_q, acc_sel_d;
    logic [IWID-1:0] cnt;
    logic [IWID-1:0] rng;
    logic            wrap;
    logic            accept;
    logic            advance;

    assign accept  = iValid && oReady;
    assign advance = (state_q == RUN) && !iFlush;

    bitstream_rng #(.IWID(IWID)) u_rng (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (advance),
        .cnt_o  (cnt),
        .rng_o  (rng),
        .wrap_o (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (iFlush)    state_d = IDLE;
                else if (wrap) state_d = accept ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oReady     = 1'b0;
        oBitValid  = 1'b0;
        oClear     = 1'b0;
        oFrameDone = 1'b0;
        case (state_q)
            IDLE: oReady = 1'b1;
            RUN: begin
                oBitValid  = 1'b1;
                oReady     = wrap && !iFlush;
                oClear     = (cnt == '0);
                oFrameDone = wrap && !iFlush;
            end
            default: ;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        acc_sel_d = acc_sel_q ^ oFrameDone;
        if (accept) data_d = iData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '{default: '0};
            acc_sel_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            acc_sel_q <= acc_sel_d;
        end
    end

    assign oAccSel   = acc_sel_q;
    assign oDbgState = state_q;

    for (genvar i = 0; i < IDIM; i++) begin : g_lane
        logic [IWID-1:0] lane_rng;
`ifdef DECORR_EN
        // Rotation is a bijection on the counter's full period, so per-frame counts are unchanged.
        localparam int ROT = i % IWID;
        if (ROT == 0) begin : g_norot
            assign lane_rng = rng;
        end else begin : g_rot
            assign lane_rng = (rng << ROT) | (rng >> (IWID - ROT));
        end
`else
        assign lane_rng = rng;
`endif
        assign oBit[i] = (data_q[i] > lane_rng);
    end

endmodule

// File: tb/tb_bitstream_gen_array.sv
// Directed bench for bitstream_gen_array: reset, per-lane counts, back-to-back, flush, lane decorrelation.
module tb_bitstream_gen_array;
  import bitstream_gen_pkg::*;

  localparam int IDIM = 4;
  localparam int IWID = 8;
  localparam int N    = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iValid = 1'b0;
  logic            iFlush = 1'b0;
  logic [IWID-1:0] iData [IDIM];
  logic            oReady;
  logic            oBit [IDIM];
  logic            oBitValid;
  logic            oAccSel;
  logic            oClear;
  logic            oFrameDone;
  state_e          oDbgState;

  int          vectors = 0;
  int          miscompares = 0;
  logic        exp_sel;
  int          ones [2][IDIM];
  logic [31:0] exp_q [$];
  logic        diff;

  bitstream_gen_array #(.IDIM(IDIM), .IWID(IWID)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iValid     (iValid),
    .oReady     (oReady),
    .iData      (iData),
    .iFlush     (iFlush),
    .oBit       (oBit),
    .oBitValid  (oBitValid),
    .oAccSel    (oAccSel),
    .oClear     (oClear),
    .oFrameDone (oFrameDone),
    .oDbgState  (oDbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int d0, input int d1, input int d2, input int d3);
    iData[0] = IWID'(d0);
    iData[1] = IWID'(d1);
    iData[2] = IWID'(d2);
    iData[3] = IWID'(d3);
  endtask

  task automatic scramble_data();
    for (int i = 0; i < IDIM; i++) iData[i] = IWID'($urandom_range(0, N - 1));
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int d0, input int d1, input int d2, input int d3);
    exp_q.push_back(32'(d0));
    exp_q.push_back(32'(d1));
    exp_q.push_back(32'(d2));
    exp_q.push_back(32'(d3));
  endtask

  task automatic check_counts(input string tag, input int f);
    logic [31:0] e;
    for (int i = 0; i < IDIM; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_lane%0d", tag, i), 32'(ones[f][i]), e);
    end
  endtask

  task automatic clear_ones();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < IDIM; i++) ones[f][i] = 0;
  endtask

  task automatic count_bits(input int f);
    for (int i = 0; i < IDIM; i++) ones[f][i] += int'(oBit[i]);
  endtask

  initial begin
    set_data(0, 0, 0, 0);

    // reset state
    #100;
    check("rst_ready", 32'(oReady), 1);
    check("rst_bitvalid", 32'(oBitValid), 0);
    check("rst_accsel", 32'(oAccSel), 0);
    check("rst_clear", 32'(oClear), 0);
    check("rst_framedone", 32'(oFrameDone), 0);
    check("rst_state", 32'(oDbgState), 32'(IDLE));
    for (int i = 0; i < IDIM; i++) check($sformatf("rst_bit%0d", i), 32'(oBit[i]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_ready", 32'(oReady), 1);
    exp_sel = 1'b0;

    // single frame counts; iData scrambled during RUN must not matter
    set_data(0, 1, 128, 255);
    push_exp(0, 1, 128, 255);
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    scramble_data();
    clear_ones();
    for (int c = 0; c < N; c++) begin
      check("cnt_bitvalid", 32'(oBitValid), 1);
      check("cnt_clear", 32'(oClear), 32'(c == 0));
      check("cnt_framedone", 32'(oFrameDone), 32'(c == N - 1));
      if (c == N - 1) check("cnt_ready_last", 32'(oReady), 1);
      count_bits(0);
      step();
    end
    exp_sel = ~exp_sel;
    check("cnt_idle", 32'(oBitValid), 0);
    check("cnt_accsel", 32'(oAccSel), 32'(exp_sel));
    check_counts("cnt", 0);

    // reset mid-frame discards the frame
    set_data(10, 20, 30, 40);
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    exp_sel = 1'b0;
    check("mrst_bitvalid", 32'(oBitValid), 0);
    check("mrst_framedone", 32'(oFrameDone), 0);
    check("mrst_accsel", 32'(oAccSel), 0);
    for (int i = 0; i < IDIM; i++) check($sformatf("mrst_bit%0d", i), 32'(oBit[i]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mrst_ready", 32'(oReady), 1);
    check("mrst_idle", 32'(oBitValid), 0);

    // back-to-back frames with iValid held high
    set_data(3, 50, 200, 17);
    push_exp(3, 50, 200, 17);
    push_exp(255, 0, 64, 100);
    iValid = 1'b1;
    step();
    set_data(255, 0, 64, 100);
    clear_ones();
    for (int c = 0; c < 2 * N; c++) begin
      check("b2b_bitvalid", 32'(oBitValid), 1);
      check("b2b_clear", 32'(oClear), 32'((c % N) == 0));
      check("b2b_framedone", 32'(oFrameDone), 32'((c % N) == N - 1));
      check("b2b_ready", 32'(oReady), 32'((c % N) == N - 1));
      count_bits(c / N);
      if (c == 2 * N - 1) iValid = 1'b0;
      step();
    end
    check("b2b_idle", 32'(oBitValid), 0);
    check("b2b_accsel", 32'(oAccSel), 0);
    check_counts("b2b_f0", 0);
    check_counts("b2b_f1", 1);

    // iFlush ignored in IDLE, then flush at cnt = 50
    set_data(5, 6, 7, 8);
    iValid = 1'b1;
    iFlush = 1'b1;
    #1;
    check("idleflush_ready", 32'(oReady), 1);
    step();
    check("idleflush_accepted", 32'(oBitValid), 1);
    check("idleflush_clear", 32'(oClear), 1);
    iValid = 1'b0;
    iFlush = 1'b0;
    repeat (50) step();
    check("fl50_clear", 32'(oClear), 0);
    iFlush = 1'b1;
    #1;
    check("fl50_ready", 32'(oReady), 0);
    check("fl50_framedone", 32'(oFrameDone), 0);
    check("fl50_bitvalid", 32'(oBitValid), 1);
    step();
    iFlush = 1'b0;
    check("fl50_idle", 32'(oBitValid), 0);
    check("fl50_state", 32'(oDbgState), 32'(IDLE));
    check("fl50_accsel", 32'(oAccSel), 32'(exp_sel));
    check("fl50_ready_idle", 32'(oReady), 1);

    // flush and accept together on the last cycle: flush wins
    set_data(1, 2, 3, 4);
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    repeat (N - 1) step();
    check("flacc_done_noflush", 32'(oFrameDone), 1);
    check("flacc_ready_noflush", 32'(oReady), 1);
    iFlush = 1'b1;
    iValid = 1'b1;
    #1;
    check("flacc_ready", 32'(oReady), 0);
    check("flacc_framedone", 32'(oFrameDone), 0);
    step();
    iFlush = 1'b0;
    iValid = 1'b0;
    check("flacc_idle", 32'(oBitValid), 0);
    check("flacc_clear", 32'(oClear), 0);
    check("flacc_accsel", 32'(oAccSel), 32'(exp_sel));
    step();
    check("flacc_still_idle", 32'(oBitValid), 0);

    // lane decorrelation with equal data on all lanes
    set_data(128, 128, 128, 128);
    push_exp(128, 128, 128, 128);
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    clear_ones();
    diff = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (oBit[0] !== oBit[1]) diff = 1'b1;
      count_bits(0);
      step();
    end
    exp_sel = ~exp_sel;
    check_counts("decorr", 0);
`ifdef DECORR_EN
    check("decorr_lanes_differ", 32'(diff), 1);
`else
    check("shared_lanes_equal", 32'(diff), 0);
`endif
    check("decorr_accsel", 32'(oAccSel), 32'(exp_sel));

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
